imem_loader: RTL

Instruction encoder and writer for the Y86-64 SEQ instruction memory. It performs the inverse of the fetch stage.
- Accepts decoded instruction fields (icode, ifun, rA, rB, valC) over a valid/ready handshake.
- Serialises them into little-endian Y86-64 byte format.
- Writes one byte per cycle into the byte-wide instruction memory at an auto-incrementing write pointer.
- Used by benches and boot logic to load programs before fetch runs.

---
 rtl/y86_pkg.sv | 58 +++++
 rtl/imem_loader_if.sv | 13 +
 rtl/y86_ilen.sv | 48 ++++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, encoded lengths, loader
// FSM states and the byte-select helper used while serialising.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ILEN_1  = 4'd1;
    localparam logic [3:0] ILEN_2  = 4'd2;
    localparam logic [3:0] ILEN_9  = 4'd9;
    localparam logic [3:0] ILEN_10 = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    // Byte k of an encoded instruction. The register byte, when present,
    // sits at index 1 and pushes the little-endian constant up by one.
    function automatic logic [7:0] instr_byte(
        input logic [3:0]  icode,
        input logic [3:0]  ifun,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [63:0] valc,
        input logic        has_regs,
        input logic        has_valc,
        input logic [3:0]  k
    );
        logic [3:0] v_idx;
        logic [7:0] v_byte;
        v_idx  = 4'd0;
        v_byte = 8'h00;
        if (k == 4'd0) begin
            v_byte = {icode, ifun};
        end else if (has_regs && (k == 4'd1)) begin
            v_byte = {ra, rb};
        end else if (has_valc) begin
            v_idx  = has_regs ? (k - 4'd2) : (k - 4'd1);
            v_byte = valc[{v_idx[2:0], 3'b000} +: 8];
        end else begin
            v_byte = 8'h00;
        end
        return v_byte;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Decoded-instruction handshake between a program source and the loader.
interface imem_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;

    modport master (output in_valid, icode, ifun, rA, rB, valC, input in_ready);
    modport slave  (input in_valid, icode, ifun, rA, rB, valC, output in_ready);
endinterface

// File: rtl/y86_ilen.sv
// Y86-64 instruction length decoder, shared with the fetch stage.
module y86_ilen
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       has_regs,
    output logic       has_valC,
    output logic       valid
);

    // Map icode to encoded length and which optional fields follow byte 0.
    always_comb begin
        len      = 4'd0;
        has_regs = 1'b0;
        has_valC = 1'b0;
        valid    = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                len   = ILEN_1;
                valid = 1'b1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                len      = ILEN_2;
                has_regs = 1'b1;
                valid    = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len      = ILEN_10;
                has_regs = 1'b1;
                has_valC = 1'b1;
                valid    = 1'b1;
            end
            I_JXX, I_CALL: begin
                len      = ILEN_9;
                has_valC = 1'b1;
                valid    = 1'b1;
            end
            default: begin
                len      = 4'd0;
                has_regs = 1'b0;
                has_valC = 1'b0;
                valid    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Encodes decoded Y86-64 instructions into little-endian bytes and writes
// them, one per cycle, into the byte-wide instruction memory.
module imem_loader
    import y86_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_addr_en,
    input  logic [ADDR_W-1:0] load_addr,
    imem_loader_if.slave      in_if,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              busy,
    output logic              instr_done,
    output logic              instr_invalid,
    output logic              imem_error
);

    // One bit wider than the pointer so the end-of-instruction sum never wraps.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_mem_we;
    logic              r_busy;
    logic              r_instr_done;
    logic              r_instr_invalid;
    logic              r_imem_error;
    logic [3:0]        r_icode;
    logic [3:0]        r_ifun;
    logic [3:0]        r_ra;
    logic [3:0]        r_rb;
    logic [63:0]       r_valc;
    logic [3:0]        r_len;
    logic [3:0]        r_idx;
    logic              r_has_regs;
    logic              r_has_valc;

    logic [3:0]        w_len;
    logic              w_has_regs;
    logic              w_has_valc;
    logic              w_valid;
    logic [ADDR_W:0]   w_end;

    y86_ilen u_ilen (
        .icode    (in_if.icode),
        .len      (w_len),
        .has_regs (w_has_regs),
        .has_valC (w_has_valc),
        .valid    (w_valid)
    );

    assign w_end = {1'b0, r_wr_ptr} + {{(ADDR_W-3){1'b0}}, w_len};

    // A pointer load in the same cycle blocks the handshake.
    assign in_if.in_ready = (r_state == S_IDLE) && !load_addr_en;

    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign wr_ptr        = r_wr_ptr;
    assign busy          = r_busy;
    assign instr_done    = r_instr_done;
    assign instr_invalid = r_instr_invalid;
    assign imem_error    = r_imem_error;

    // Loader FSM: accept, serialise byte by byte, or park in ERROR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wr_ptr        <= '0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= 8'h00;
            r_mem_we        <= 1'b0;
            r_busy          <= 1'b0;
            r_instr_done    <= 1'b0;
            r_instr_invalid <= 1'b0;
            r_imem_error    <= 1'b0;
            r_icode         <= 4'h0;
            r_ifun          <= 4'h0;
            r_ra            <= 4'h0;
            r_rb            <= 4'h0;
            r_valc          <= 64'h0;
            r_len           <= 4'd0;
            r_idx           <= 4'd0;
            r_has_regs      <= 1'b0;
            r_has_valc      <= 1'b0;
        end else begin
            r_instr_invalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_mem_we     <= 1'b0;
                    r_busy       <= 1'b0;
                    r_instr_done <= 1'b0;
                    if (load_addr_en) begin
                        r_wr_ptr <= load_addr;
                    end else if (in_if.in_valid) begin
                        if (!w_valid) begin
                            r_instr_invalid <= 1'b1;
                        end else if (w_end > MEM_LIMIT) begin
                            r_imem_error <= 1'b1;
                            r_state      <= S_ERROR;
                        end else begin
                            // Latch fields and put byte 0 out straight away.
                            r_icode      <= in_if.icode;
                            r_ifun       <= in_if.ifun;
                            r_ra         <= in_if.rA;
                            r_rb         <= in_if.rB;
                            r_valc       <= in_if.valC;
                            r_len        <= w_len;
                            r_has_regs   <= w_has_regs;
                            r_has_valc   <= w_has_valc;
                            r_idx        <= 4'd0;
                            r_mem_we     <= 1'b1;
                            r_mem_addr   <= r_wr_ptr;
                            r_mem_wdata  <= {in_if.icode, in_if.ifun};
                            r_busy       <= 1'b1;
                            r_instr_done <= (w_len == ILEN_1);
                            r_state      <= S_WRITE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (r_idx == (r_len - 4'd1)) begin
                        // Last byte is on the bus now; retire the instruction.
                        r_mem_we     <= 1'b0;
                        r_busy       <= 1'b0;
                        r_instr_done <= 1'b0;
                        r_wr_ptr     <= r_wr_ptr + {{(ADDR_W-4){1'b0}}, r_len};
                        r_state      <= S_IDLE;
                    end else begin
                        r_idx        <= r_idx + 4'd1;
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= r_mem_addr + ADDR_W'(1);
                        r_mem_wdata  <= instr_byte(r_icode, r_ifun, r_ra, r_rb, r_valc,
                                                   r_has_regs, r_has_valc, r_idx + 4'd1);
                        r_busy       <= 1'b1;
                        r_instr_done <= ((r_idx + 4'd2) == r_len);
                    end
                end
                S_ERROR: begin
                    r_mem_we     <= 1'b0;
                    r_busy       <= 1'b0;
                    r_instr_done <= 1'b0;
                    r_state      <= S_ERROR;
                end
                default: begin
                    r_mem_we     <= 1'b0;
                    r_busy       <= 1'b0;
                    r_instr_done <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
